// File: rtl/fbcpu_mem_responder.sv
// rtl/fbcpu_mem_responder.sv - FBCPU memory-side responder with streaming program-load port
//
// Purpose:
//   Holds DEPTH = 2**ADDRESS_WIDTH words of DATA_WIDTH bits for the FBCPU core bus.
//   The CPU side has a 1-cycle registered read (MDROut <= mem[MAR] every edge in IDLE)
//   and a level-sampled write strobe. A valid/ready load stream fills memory from
//   address 0 while busy holds the CPU in reset.
//
// Configuration:
//   FBCPU_MEM_CLEAR_EN - when defined, reset enters a CLEAR state that zeroes every
//   word (one per cycle, DEPTH cycles) before returning to IDLE. When undefined,
//   reset goes straight to IDLE and memory contents persist across reset.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   MAR, MDRIn, RAMWr   CPU address, write data, write strobe
//   MDROut              registered read data
//   ld_start            pulse: begin a load at address 0 (ignored while busy)
//   ld_valid, ld_data   load word handshake and payload
//   ld_last             marks the final load word
//   ld_ready            load word accepted when ld_valid & ld_ready
//   busy                high in LOAD/CLEAR

module fbcpu_mem_responder #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  input  logic                     RAMWr,
  output logic [DATA_WIDTH-1:0]    MDROut,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_PTR = {ADDRESS_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

`ifdef FBCPU_MEM_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t                  state, state_nx;
  logic [ADDRESS_WIDTH-1:0] ptr, ptr_nx;
  logic                    mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    rd_en;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // One write port shared by CPU writes, load stream and clear sweep; the
  // state decides which source owns it. ptr is never compared past LAST_PTR,
  // so its wrap after the final word is harmless.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    mem_we    = 1'b0;
    mem_addr  = MAR;
    mem_wdata = MDRIn;
    rd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        rd_en  = 1'b1;
        mem_we = RAMWr;
        if (ld_start) begin
          state_nx = S_LOAD;
          ptr_nx   = '0;
        end
      end
      S_LOAD: begin
        // ld_ready is high for the whole LOAD state, so ld_valid alone is the accept.
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ptr;
          mem_wdata = ld_data;
          ptr_nx    = ptr + 1'b1;
          if (ld_last || ptr == LAST_PTR) begin
            state_nx = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
`ifdef FBCPU_MEM_CLEAR_EN
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = '0;
        ptr_nx    = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_nx = S_IDLE;
        end
`else
        state_nx = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory is not reset; writes are suppressed while rst is high so a reset
  // cycle never disturbs contents (and the clear sweep starts after rst falls).
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Read samples the array before the same-edge write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      MDROut <= '0;
    end else if (rd_en) begin
      MDROut <= mem[MAR];
    end
  end

  assign ld_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_fbcpu_mem_responder.sv
// tb/tb_fbcpu_mem_responder.sv - self-checking bench for fbcpu_mem_responder
module tb_fbcpu_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] MAR;
  logic [9:0] MDRIn;
  logic       RAMWr;
  logic [9:0] MDROut;
  logic       ld_start;
  logic       ld_valid;
  logic [9:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [9:0] model [64];
  logic [9:0] words [$];

  fbcpu_mem_responder #(.ADDRESS_WIDTH(6), .DATA_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .MAR(MAR), .MDRIn(MDRIn), .RAMWr(RAMWr), .MDROut(MDROut),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef FBCPU_MEM_CLEAR_EN
  localparam logic BUSY_IN_RESET = 1'b1;
`else
  localparam logic BUSY_IN_RESET = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [5:0] a);
    MAR = a;
    RAMWr = 1'b0;
    tick();
    chk(tag, {22'd0, MDROut}, {22'd0, model[a]});
  endtask

  // Write edge returns the old word; model updated afterwards.
  task automatic wr(input string tag, input logic [5:0] a, input logic [9:0] d);
    MAR = a;
    MDRIn = d;
    RAMWr = 1'b1;
    tick();
    RAMWr = 1'b0;
    chk(tag, {22'd0, MDROut}, {22'd0, model[a]});
    model[a] = d;
  endtask

  // Clear sweep: busy must stay high for exactly 64 edges after rst falls.
  task automatic wait_clear();
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("clear_cycles", cnt, 64);
    for (int i = 0; i < 64; i++) model[i] = 10'd0;
  endtask

  // Streams words[] from address 0. gap_at forces a 1-cycle valid gap before that index.
  task automatic load_words(input logic last_on_final, input int gapmax, input int gap_at);
    int n;
    int g;
    logic done;
    n = words.size();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("load_start_busy", {31'd0, busy}, 1);
    chk("load_start_ready", {31'd0, ld_ready}, 1);
    for (int i = 0; i < n; i++) begin
      g = (i == gap_at) ? 1 : $urandom_range(0, gapmax);
      for (int k = 0; k < g; k++) begin
        ld_valid = 1'b0;
        tick();
        chk("load_gap_ready", {31'd0, ld_ready}, 1);
      end
      ld_valid = 1'b1;
      ld_data = words[i];
      ld_last = last_on_final && (i == n - 1);
      tick();
      model[i] = words[i];
      ld_valid = 1'b0;
      ld_last = 1'b0;
      done = (i == n - 1) && (last_on_final || n == 64);
      chk("load_busy", {31'd0, busy}, {31'd0, !done});
      chk("load_ready", {31'd0, ld_ready}, {31'd0, !done});
    end
  endtask

  initial begin
    logic [9:0] hold_exp;
    logic [5:0] a;
    int n;

    rst = 1'b1; MAR = '0; MDRIn = '0; RAMWr = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 'x;
    tick();
    tick();
    chk("reset_mdrout", {22'd0, MDROut}, 0);
    chk("reset_ready", {31'd0, ld_ready}, 0);
    chk("reset_busy", {31'd0, busy}, {31'd0, BUSY_IN_RESET});
    rst = 1'b0;
`ifdef FBCPU_MEM_CLEAR_EN
    wait_clear();
`endif

    // T4 full load, no ld_last: auto exit after word 64; 65th word refused
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back(10'(i));
    load_words(1'b0, 0, -1);
    ld_valid = 1'b1;
    ld_data = 10'h3AB;
    tick();
    chk("t4_65th_ready", {31'd0, ld_ready}, 0);
    chk("t4_65th_busy", {31'd0, busy}, 0);
    ld_valid = 1'b0;
    rd("t4_mem0", 6'd0);
    rd("t4_mem63", 6'd63);

    // T1 basic RW
    wr("t1_wr", 6'd5, 10'h2A5);
    rd("t1_rd", 6'd5);
    chk("t1_value", {22'd0, MDROut}, 32'h2A5);

    // T2 read-during-write
    wr("t2_pre", 6'd3, 10'h011);
    wr("t2_rbw", 6'd3, 10'h3FF);
    chk("t2_old", {22'd0, MDROut}, 32'h011);
    rd("t2_new", 6'd3);
    chk("t2_value", {22'd0, MDROut}, 32'h3FF);

    // T3 short load with gap before the second word
    words.delete();
    words.push_back(10'h101);
    words.push_back(10'h102);
    words.push_back(10'h103);
    load_words(1'b1, 0, 1);
    rd("t3_mem0", 6'd0);
    rd("t3_mem1", 6'd1);
    rd("t3_mem2", 6'd2);
    rd("t3_mem3", 6'd3);

    // Random IDLE traffic against the model
    for (int i = 0; i < 200; i++) begin
      a = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) wr("rand_wr", a, 10'($urandom));
      else rd("rand_rd", a);
    end

    // Random loads
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 64);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(10'($urandom));
      load_words((n < 64) ? 1'b1 : 1'($urandom_range(0, 1)), 2, -1);
      for (int i = 0; i < 16; i++) rd("rand_load_rd", 6'($urandom_range(0, 63)));
    end

    // T5 reset mid-load, with a CPU write attempted during LOAD
    MAR = 6'd9;
    hold_exp = model[9];
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 10'h155;
    tick();
    model[0] = 10'h155;
    ld_data = 10'h2AA;
    tick();
    model[1] = 10'h2AA;
    ld_valid = 1'b0;
    chk("t5_ready_mid", {31'd0, ld_ready}, 1);
    MAR = 6'd2; MDRIn = 10'h0F0; RAMWr = 1'b1;
    tick();
    RAMWr = 1'b0;
    chk("t5_mdr_hold", {22'd0, MDROut}, {22'd0, hold_exp});
    rst = 1'b1;
    tick();
    chk("t5_rst_busy", {31'd0, busy}, {31'd0, BUSY_IN_RESET});
    chk("t5_rst_ready", {31'd0, ld_ready}, 0);
    chk("t5_rst_mdr", {22'd0, MDROut}, 0);
    rst = 1'b0;
`ifdef FBCPU_MEM_CLEAR_EN
    wait_clear();
`endif
    rd("t5_mem0", 6'd0);
    rd("t5_mem1", 6'd1);
    rd("t5_mem2", 6'd2);

    // T6 reset behaviour with respect to memory contents
    wr("t6_pre", 6'd10, 10'h3C3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef FBCPU_MEM_CLEAR_EN
    wait_clear();
    rd("t6_mem10", 6'd10);
    chk("t6_value", {22'd0, MDROut}, 0);
`else
    chk("t6_busy", {31'd0, busy}, 0);
    rd("t6_mem10", 6'd10);
    chk("t6_value", {22'd0, MDROut}, 32'h3C3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
